// File: rtl/uart_rx_fifo_if.sv
// Read-side bus between the MMIO decoder (master) and the UART receive FIFO (slave).
// Handshake: valid=1 means rdata holds the head byte; a one-cycle rd_en while valid pops it, and rd_en while !valid is ignored.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                rd_en;
  logic                clr_err;
  logic [7:0]          rdata;
  logic                valid;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                frame_err;
  logic                busy;

  modport master (
    output rd_en, clr_err,
    input  rdata, valid, count, overrun, frame_err, busy
  );

  modport slave (
    input  rd_en, clr_err,
    output rdata, valid, count, overrun, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 console receiver feeding a first-word-fall-through byte FIFO with sticky
// framing-error and overrun flags.
module uart_rx_fifo #(
  parameter int SERIAL_WCNT = 100,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rxd,
  uart_rx_fifo_if.slave     bus,
  output logic [2:0]        dbg_state
);
  localparam int BW    = $clog2(SERIAL_WCNT);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t              state, state_next;
  logic                rxd_m, rxd_s;
  logic [BW-1:0]       bcnt, tgt_m1;
  logic                tick;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                push, fe_set, shift_en;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] cnt;
  logic                full, empty, do_pop, do_push, ovr_set;
  logic                overrun_q, frame_err_q;

  // Both stages reset high so a line held low after reset still needs a fresh edge.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_comb begin
    tgt_m1 = (state == S_START) ? BW'(SERIAL_WCNT / 2 - 1) : BW'(SERIAL_WCNT - 1);
    tick   = (bcnt == tgt_m1);
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    fe_set     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE:  if (!rxd_s) state_next = S_START;
      S_START: if (tick) state_next = rxd_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rxd_s) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            fe_set     = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: if (rxd_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The baud counter restarts on every state entry and on every bit tick.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state   <= S_IDLE;
      bcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || tick) bcnt <= '0;
      else                             bcnt <= bcnt + BW'(1);
      if (state == S_START)  bit_idx <= '0;
      else if (shift_en)     bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
    end
  end

  always_comb begin
    full    = (cnt == (DEPTH_LOG2+1)'(DEPTH));
    empty   = (cnt == '0);
    do_pop  = bus.rd_en && !empty;
    do_push = push && (!full || do_pop);
    ovr_set = push && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (DEPTH_LOG2+1)'(1);
        2'b01:   cnt <= cnt - (DEPTH_LOG2+1)'(1);
        default: cnt <= cnt;
      endcase
      // A new error event in the clearing cycle keeps its flag set.
      overrun_q   <= (overrun_q   && !bus.clr_err) || ovr_set;
      frame_err_q <= (frame_err_q && !bus.clr_err) || fe_set;
    end
  end

  assign bus.rdata     = empty ? 8'h00 : mem[rd_ptr];
  assign bus.valid     = !empty;
  assign bus.count     = cnt;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != S_IDLE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are driven bit by bit, the
// bytes the FIFO should hold are queued and compared as they are popped.
module tb_uart_rx_fifo;
  localparam int W      = 8;
  localparam int DL     = 2;
  localparam int PUSH_C = 2 + W / 2 + 9 * W;

  logic       clk = 1'b0;
  logic       rst_async;
  logic       rxd;
  logic [2:0] dbg_state;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(.SERIAL_WCNT(W), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .rxd       (rxd),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] head_at_push;
  logic [7:0] exp_b;
  logic [7:0] got_b;
  logic       got_v;

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full frame, one line value per clock; optional pop on the push cycle
  // and optional reset pulse that aborts the frame.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit,
                           input logic pop_at_push, input int rst_at);
    for (int c = 0; c < 10 * W; c++) begin
      int b;
      b = c / W;
      if (b == 0)     rxd = 1'b0;
      else if (b < 9) rxd = data[b-1];
      else            rxd = stop_bit;
      bus.rd_en = pop_at_push && (c == PUSH_C);
      if (pop_at_push && c == PUSH_C) head_at_push = bus.rdata;
      if (rst_at >= 0 && c == rst_at) rst_async = 1'b1;
      @(negedge clk);
      if (rst_at >= 0 && c == rst_at) begin
        @(negedge clk);
        rxd       = 1'b1;
        bus.rd_en = 1'b0;
        rst_async = 1'b0;
        return;
      end
    end
    bus.rd_en = 1'b0;
    rxd       = 1'b1;
  endtask

  task automatic pop_byte(output logic [7:0] b, output logic v);
    b         = bus.rdata;
    v         = bus.valid;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_async   = 1'b1;
    rxd         = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    idle_cycles(3);
    checks++;
    if ({bus.rdata, bus.valid, bus.count, bus.overrun, bus.frame_err, bus.busy, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdata=%h valid=%b count=%0d ovr=%b fe=%b busy=%b state=%0d, expected all zero",
               bus.rdata, bus.valid, bus.count, bus.overrun, bus.frame_err, bus.busy, dbg_state);
    end
    rst_async = 1'b0;
    idle_cycles(2);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", bus.busy, bus.valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0, -1);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, 1'b0, -1);
    checks++;
    if (bus.count !== 3'd2 || bus.rdata !== exp_q[0]) begin
      errors++;
      $display("FAIL b2b_count: count=%0d rdata=%h, expected 2 %h", bus.count, bus.rdata, exp_q[0]);
    end
    pop_byte(got_b, got_v);
    exp_b = exp_q.pop_front();
    checks++;
    if (bus.rdata !== exp_q[0] || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next_head: rdata=%h valid=%b, expected %h 1", bus.rdata, bus.valid, exp_q[0]);
    end
    pop_byte(got_b, got_v);
    exp_b = exp_q.pop_front();
    checks++;
    if (got_b !== exp_b || bus.valid !== 1'b0 || bus.rdata !== 8'h00 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drain: popped=%h valid=%b rdata=%h count=%0d, expected %h 0 00 0",
               got_b, bus.valid, bus.rdata, bus.count, exp_b);
    end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    saw_busy = 1'b0;
    rxd = 1'b0;
    idle_cycles(2);
    rxd = 1'b1;
    for (int i = 0; i < W / 2 + 4; i++) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start_seen: busy never rose, expected 1");
    end
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== 3'd0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b state=%0d count=%0d, expected 0 0 0", bus.busy, dbg_state, bus.count);
    end
  endtask

  task automatic test_frame_error();
    send_byte(8'h3C, 1'b0, 1'b0, -1);
    rxd = 1'b0;
    idle_cycles(40);
    rxd = 1'b1;
    idle_cycles(W);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 1'b0, -1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL fe_flag: frame_err=%b overrun=%b, expected 1 0", bus.frame_err, bus.overrun);
    end
    checks++;
    if (bus.count !== 3'd1 || bus.rdata !== exp_q[0]) begin
      errors++;
      $display("FAIL fe_fifo: count=%0d rdata=%h, expected 1 %h", bus.count, bus.rdata, exp_q[0]);
    end
    pulse_clr();
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL fe_clear: frame_err=%b, expected 0", bus.frame_err);
    end
    pop_byte(got_b, got_v);
    exp_b = exp_q.pop_front();
    checks++;
    if (got_b !== exp_b || got_v !== 1'b1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL fe_pop: popped=%h valid_before=%b valid_after=%b, expected %h 1 0",
               got_b, got_v, bus.valid, exp_b);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0, -1);
    end
    checks++;
    if (bus.count !== 3'd4 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_full: count=%0d overrun=%b, expected 4 1", bus.count, bus.overrun);
    end
    while (exp_q.size() > 0) begin
      pop_byte(got_b, got_v);
      exp_b = exp_q.pop_front();
      checks++;
      if (got_b !== exp_b || got_v !== 1'b1) begin
        errors++;
        $display("FAIL ovr_pop: got %h valid=%b, expected %h 1", got_b, got_v, exp_b);
      end
    end
    pulse_clr();
    checks++;
    if (bus.overrun !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: overrun=%b valid=%b, expected 0 0", bus.overrun, bus.valid);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_byte(8'h11 + 8'(i), 1'b1, (i == 4), -1);
    end
    exp_b = exp_q.pop_front();
    checks++;
    if (head_at_push !== exp_b || bus.overrun !== 1'b0 || bus.count !== 3'd4) begin
      errors++;
      $display("FAIL ovr_simul: popped=%h overrun=%b count=%0d, expected %h 0 4",
               head_at_push, bus.overrun, bus.count, exp_b);
    end
    while (exp_q.size() > 0) begin
      pop_byte(got_b, got_v);
      exp_b = exp_q.pop_front();
      checks++;
      if (got_b !== exp_b || got_v !== 1'b1) begin
        errors++;
        $display("FAIL ovr_simul_pop: got %h valid=%b, expected %h 1", got_b, got_v, exp_b);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0, -1);
      idle_cycles($urandom_range(0, 3));
      checks++;
      if (bus.count !== 3'd1) begin
        errors++;
        $display("FAIL wrap_count: byte %0d count=%0d, expected 1", i, bus.count);
      end
      pop_byte(got_b, got_v);
      exp_b = exp_q.pop_front();
      checks++;
      if (got_b !== exp_b || got_v !== 1'b1) begin
        errors++;
        $display("FAIL wrap_data: got %h valid=%b, expected %h 1", got_b, got_v, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_q.push_back(8'hA1);
    send_byte(8'hA1, 1'b1, 1'b0, -1);
    exp_q.push_back(8'hB2);
    send_byte(8'hB2, 1'b1, 1'b0, -1);
    checks++;
    if (bus.count !== 3'd2) begin
      errors++;
      $display("FAIL rst_prequeue: count=%0d, expected 2", bus.count);
    end
    send_byte(8'h5A, 1'b1, 1'b0, 5 * W + 3);
    exp_q.delete();
    checks++;
    if ({bus.rdata, bus.valid, bus.count, bus.overrun, bus.frame_err, bus.busy, dbg_state} !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: rdata=%h valid=%b count=%0d ovr=%b fe=%b busy=%b state=%0d, expected all zero",
               bus.rdata, bus.valid, bus.count, bus.overrun, bus.frame_err, bus.busy, dbg_state);
    end
    idle_cycles(2 * W);
    exp_q.push_back(8'hC9);
    send_byte(8'hC9, 1'b1, 1'b0, -1);
    checks++;
    if (bus.count !== 3'd1 || bus.rdata !== exp_q[0] || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_frame: count=%0d rdata=%h fe=%b, expected 1 %h 0",
               bus.count, bus.rdata, bus.frame_err, exp_q[0]);
    end
    pop_byte(got_b, got_v);
    exp_b = exp_q.pop_front();
    checks++;
    if (got_b !== exp_b || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_pop: got %h valid_after=%b, expected %h 0", got_b, bus.valid, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Console-input UART receiver with a byte FIFO, the host-to-target counterpart of the MMIO transmit path. It deserializes 8N1 frames from `uart_rxd` after program load and buffers them. The MMIO decoder then serves them to the processor as a read-data/pop interface alongside `MMIO_TO_HOST`. Framing errors and FIFO overruns are latched in sticky flags for software polling.

## Interface
- `SERIAL_WCNT`, 100: clock cycles per bit (CPU_FREQ/BAUDRATE); must be ≥ 4.
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 bytes.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_async`  in  1  reset, asynchronous, active-high.
- `rxd`  in  1  raw serial input, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pop head byte (one-cycle pulse from MMIO read).
- `rdata`  out  8  head byte (first-word-fall-through); 8'h00 when empty.
- `valid`  out  1  FIFO non-empty.
- `count`  out  DEPTH_LOG2+1  bytes held, 0..2^DEPTH_LOG2.
- `overrun`  out  1  sticky: byte dropped because FIFO full.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `busy`  out  1  receiver not in IDLE.

## Operation
- Synchronizer: 2-FF on `rxd`, both reset to 1; FSM sees only `rxd_s`.
- Baud counter `bcnt`, width clog2(SERIAL_WCNT): cleared on every state entry; "tick" when `bcnt == target-1`.
- States:
  - IDLE: `rxd_s==0` → START.
  - START: target SERIAL_WCNT/2 (integer division). At tick, `rxd_s==1` → IDLE (glitch, nothing recorded); else → DATA with bit index 0.
  - DATA: target SERIAL_WCNT. At each tick, shift `rxd_s` in LSB-first. After the 8th bit → STOP.
  - STOP: target SERIAL_WCNT. At tick, `rxd_s==1` → push byte, → IDLE. `rxd_s==0` → set `frame_err`, discard byte, → BREAK.
  - BREAK: wait for `rxd_s==1` → IDLE. A held-low line yields exactly one error and no bytes.
- FIFO: circular buffer, DEPTH_LOG2-bit pointers, and a separate `count` register to distinguish full from empty.
  - Push when not full: write at `wr_ptr`, increment.
  - Push when full and no pop in the same cycle: byte dropped, `overrun` set, pointers unchanged.
  - Push and pop in the same cycle when full: both happen, `count` unchanged, no overrun.
  - Push and pop in the same cycle when empty: push only. New byte is visible the next cycle; the pop is ignored.
  - Pop when empty: ignored, no error.
  - Pointers wrap modulo depth.
- Sticky flags: a set in the same cycle as `clr_err` wins (the flag stays 1).
- `rst_async` mid-frame: FSM → IDLE, FIFO emptied, flags cleared, partial byte lost. After deassertion the synchronizer starts at 1, so a low line must be seen as a fresh falling edge. A frame already in progress is resynced by the START-check or STOP/BREAK logic.

## Timing
- Reset values: `rdata`=0, `valid`=0, `count`=0, `overrun`=0, `frame_err`=0, `busy`=0.
- `rxd` falling edge → IDLE→START transition: 2 cycles of synchronizer, plus 1 cycle.
- START-bit centre check at SERIAL_WCNT/2 cycles after START entry. Data bit k sampled (k+1)·SERIAL_WCNT cycles after that. Stop sampled at 9·SERIAL_WCNT.
- Push on the stop-sample cycle; `valid`/`count`/`rdata` update on the next rising edge.
- Pop: `rdata` shows the next byte one cycle after the `rd_en` edge (registered head read, FWFT).
- `busy` is high from the cycle after START entry through the STOP/BREAK exit cycle.
- Back-to-back frames: IDLE is re-entered half a bit early, so a next start bit arriving immediately after the stop bit is caught.

## Test plan
- SERIAL_WCNT=8: send 0x55 then 0xA3 back-to-back → `count`=2, `rdata`=0x55. Pulse `rd_en` → `rdata`=0xA3. Pulse again → `valid`=0, `rdata`=0x00.
- Glitch test: drive `rxd` low for 2 cycles only → no push, `busy` returns to 0, FSM in IDLE within SERIAL_WCNT/2+4 cycles.
- Frame error: send 0x3C with stop bit 0, then hold `rxd` low for 40 cycles, then send 0x7E → `frame_err`=1, FIFO holds only 0x7E. Pulse `clr_err` → `frame_err`=0.
- Overrun: DEPTH_LOG2=2; send 5 bytes 0x01..0x05 with no pops → `count`=4, `overrun`=1, pops return 0x01..0x04. Repeat the full-FIFO case with `rd_en` asserted on the 5th push cycle → no overrun, 0x05 retained.
- Wrap: push/pop 20 bytes (0x00..0x13) one at a time → every byte read in order, `count` never exceeds 1.
- Reset mid-frame: assert `rst_async` during data bit 4 with 2 bytes queued → all outputs at reset values. The next clean frame 0xC9 is received correctly.
